// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared pipeline defines for the hazard controller
package hazard_ctrl_pkg;
  localparam int REG_W = 5;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import hazard_ctrl_pkg::*;

  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRt;
  logic             ID_Jump;
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic [REG_W-1:0] EX_Write_register;
  logic             EX_BranchTaken;
  logic             MEM_Access;
  logic             mem_ready;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Stall;
  logic             Pipe_Freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_Jump, EX_MemRead, EX_RegWrite,
           EX_Write_register, EX_BranchTaken, MEM_Access, mem_ready,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Stall, Pipe_Freeze,
           mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_Jump, EX_MemRead, EX_RegWrite,
           EX_Write_register, EX_BranchTaken, MEM_Access, mem_ready,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Stall, Pipe_Freeze,
           mem_timeout, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/freeze control with memory-wait watchdog
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);
  localparam int WC_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_nxt;
  logic            timeout_q;
  logic            freeze, load_use;
  logic            pc_write, ifid_write, ifid_flush, idex_stall, pipe_freeze;

  assign freeze   = hz.MEM_Access && !hz.mem_ready;
  assign load_use = hz.EX_MemRead && hz.EX_RegWrite && (hz.EX_Write_register != '0) &&
                    ((hz.EX_Write_register == hz.ID_Rs) ||
                     (hz.ID_UsesRt && (hz.EX_Write_register == hz.ID_Rt)));

  // Priority: memory freeze, then taken branch, then load-use, then jump.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    pipe_freeze = 1'b0;
    if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else if (hz.EX_BranchTaken) begin
      ifid_flush = 1'b1;
      idex_stall = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_stall = 1'b1;
    end else if (hz.ID_Jump) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        wait_nxt = '0;
        if (freeze) state_nxt = WAIT;
      end
      WAIT: begin
        if (!freeze) state_nxt = RUN;
        if (wait_cnt != WC_MAX) wait_nxt = wait_cnt + 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (wait_nxt == WC_MAX) timeout_q <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .clr  (reset),
    .inc  (freeze || (load_use && !hz.EX_BranchTaken)),
    .count(hz.stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk  (clk),
    .clr  (reset),
    .inc  (ifid_flush),
    .count(hz.flush_count)
  );

  assign hz.PC_Write    = pc_write;
  assign hz.IFID_Write  = ifid_write;
  assign hz.IFID_Flush  = ifid_flush;
  assign hz.IDEX_Stall  = idex_stall;
  assign hz.Pipe_Freeze = pipe_freeze;
  assign hz.mem_timeout = timeout_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       jp;
    logic       mrd;
    logic       rwr;
    logic [4:0] wr;
    logic       br;
    logic       acc;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic       pcw;
    logic       ifw;
    logic       fl;
    logic       stl;
    logic       fz;
    logic       st;
    logic       mto;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  localparam logic [4:0] IDLE = 5'b11000;
  localparam logic [4:0] LU   = 5'b00010;
  localparam logic [4:0] BR   = 5'b11110;
  localparam logic [4:0] JP   = 5'b11100;
  localparam logic [4:0] FZ   = 5'b00001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) hz ();

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  int    total = 0;
  int    passed = 0;
  int    m_stall = 0;
  int    m_flush = 0;
  out_t  exp_q[$];
  vec_t  vecs[$];

  function automatic in_t mi(logic rst, logic [4:0] rs, logic [4:0] rt, logic ur, logic jp,
                             logic mrd, logic rwr, logic [4:0] wr, logic br, logic acc, logic rdy);
    mi = {rst, rs, rt, ur, jp, mrd, rwr, wr, br, acc, rdy};
  endfunction

  function automatic out_t mo(logic [4:0] ctl, logic st, logic mto);
    mo = {ctl, st, mto};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic step(input int n, input in_t v, input out_t e);
    out_t ex;
    reset                = v.rst;
    hz.ID_Rs             = v.rs;
    hz.ID_Rt             = v.rt;
    hz.ID_UsesRt         = v.ur;
    hz.ID_Jump           = v.jp;
    hz.EX_MemRead        = v.mrd;
    hz.EX_RegWrite       = v.rwr;
    hz.EX_Write_register = v.wr;
    hz.EX_BranchTaken    = v.br;
    hz.MEM_Access        = v.acc;
    hz.mem_ready         = v.rdy;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk($sformatf("scoreboard_empty[%0d]", n), 32'd1, 32'd0);
    end else begin
      ex = exp_q.pop_front();
      chk($sformatf("PC_Write[%0d]", n), 32'(hz.PC_Write), 32'(ex.pcw));
      chk($sformatf("IFID_Write[%0d]", n), 32'(hz.IFID_Write), 32'(ex.ifw));
      chk($sformatf("IFID_Flush[%0d]", n), 32'(hz.IFID_Flush), 32'(ex.fl));
      chk($sformatf("IDEX_Stall[%0d]", n), 32'(hz.IDEX_Stall), 32'(ex.stl));
      chk($sformatf("Pipe_Freeze[%0d]", n), 32'(hz.Pipe_Freeze), 32'(ex.fz));
      chk($sformatf("state[%0d]", n), 32'(dut.state), 32'(ex.st));
      chk($sformatf("mem_timeout[%0d]", n), 32'(hz.mem_timeout), 32'(ex.mto));
      chk($sformatf("stall_count[%0d]", n), 32'(hz.stall_count), 32'(m_stall));
      chk($sformatf("flush_count[%0d]", n), 32'(hz.flush_count), 32'(m_flush));
      if (v.rst) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        m_stall += int'(ex.fz || (ex.stl && !ex.fl));
        m_flush += int'(ex.fl);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_t idle_in, frz, frz_all;
    idle_in = mi(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 0);
    frz     = mi(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0);
    frz_all = mi(0, 5'd8, 5'd0, 0, 1, 1, 1, 5'd8, 1, 1, 0);

    // Combinational priority table after power-on reset
    vecs.push_back('{idle_in, mo(IDLE, 0, 0)});
    vecs.push_back('{mi(0, 5'd8, 5'd0, 0, 0, 1, 1, 5'd8, 0, 0, 0), mo(LU, 0, 0)});
    vecs.push_back('{mi(0, 5'd0, 5'd0, 0, 0, 1, 1, 5'd0, 0, 0, 0), mo(IDLE, 0, 0)});
    vecs.push_back('{mi(0, 5'd3, 5'd9, 1, 0, 1, 1, 5'd9, 0, 0, 0), mo(LU, 0, 0)});
    vecs.push_back('{mi(0, 5'd3, 5'd9, 0, 0, 1, 1, 5'd9, 0, 0, 0), mo(IDLE, 0, 0)});
    vecs.push_back('{mi(0, 5'd8, 5'd0, 0, 0, 0, 1, 5'd8, 0, 0, 0), mo(IDLE, 0, 0)});
    vecs.push_back('{mi(0, 5'd8, 5'd0, 0, 0, 1, 1, 5'd8, 1, 0, 0), mo(BR, 0, 0)});
    vecs.push_back('{mi(0, 5'd1, 5'd2, 0, 1, 0, 0, 5'd0, 0, 0, 0), mo(JP, 0, 0)});
    vecs.push_back('{mi(0, 5'd8, 5'd0, 0, 1, 1, 1, 5'd8, 0, 0, 0), mo(LU, 0, 0)});
    vecs.push_back('{mi(0, 5'd1, 5'd2, 0, 1, 0, 0, 5'd0, 1, 0, 0), mo(BR, 0, 0)});
    vecs.push_back('{mi(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 1, 1), mo(IDLE, 0, 0)});
    vecs.push_back('{idle_in, mo(IDLE, 0, 0)});

    hz.ID_Rs = '0; hz.ID_Rt = '0; hz.ID_UsesRt = 0; hz.ID_Jump = 0;
    hz.EX_MemRead = 0; hz.EX_RegWrite = 0; hz.EX_Write_register = '0;
    hz.EX_BranchTaken = 0; hz.MEM_Access = 0; hz.mem_ready = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < vecs.size(); k++) step(k, vecs[k].in, vecs[k].exp);

    // Three-cycle freeze overriding branch, load-use and jump
    step(100, mi(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 0), mo(IDLE, 0, 0));
    step(101, frz_all, mo(FZ, 0, 0));
    step(102, frz_all, mo(FZ, 1, 0));
    step(103, frz_all, mo(FZ, 1, 0));
    step(104, mi(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 1, 1), mo(IDLE, 1, 0));
    step(105, idle_in, mo(IDLE, 0, 0));
    chk("stall_count_after_freeze", 32'(hz.stall_count), 32'd3);

    // Watchdog with TIMEOUT=4: six waiting cycles, then ready, then reset
    step(200, mi(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 0), mo(IDLE, 0, 0));
    for (int k = 0; k < 6; k++) step(201 + k, frz, mo(FZ, k != 0, k == 5));
    step(207, mi(0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1), mo(IDLE, 1, 1));
    step(208, idle_in, mo(IDLE, 0, 1));
    step(209, idle_in, mo(IDLE, 0, 1));
    step(210, mi(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0, 0), mo(IDLE, 0, 1));
    step(211, idle_in, mo(IDLE, 0, 0));

    // Reset arriving while in WAIT
    step(300, frz, mo(FZ, 0, 0));
    step(301, frz, mo(FZ, 1, 0));
    step(302, mi(1, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0), mo(FZ, 1, 0));
    step(303, idle_in, mo(IDLE, 0, 0));
    chk("stall_count_after_reset", 32'(hz.stall_count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
